spi_arb: RTL and testbench
==========================

# spi_arb

Two-requester arbiter that shares one SPI master between the A2D interface (load cells and battery) and the inertial-sensor interface. It serialises their transactions and steers the SS_n/MISO mux. It sits between the requesting interfaces inside the Segway top level and the single SPI master, in the `rst_synch` domain. Arbitration is round-robin, and a watchdog terminates any transaction whose master never completes.

## Interface
Parameters:
- TIMEOUT_W, 12, width of the BUSY watchdog counter; timeout fires after 2^TIMEOUT_W−1 BUSY cycles without `spi_done`

Ports:
- clk  in  1  system clock; single clock domain
- rst_n  in  1  asynchronous active-low reset, from `rst_synch`
- req_a2d  in  1  A2D request; level, held until `done_a2d`
- cmd_a2d  in  16  A2D SPI command word; must be stable while `req_a2d` is high
- req_inert  in  1  inertial request; level, held until `done_inert`
- cmd_inert  in  16  inertial SPI command word; must be stable while `req_inert` is high
- gnt_a2d  out  1  A2D owns the master
- gnt_inert  out  1  inertial interface owns the master
- done_a2d  out  1  one-cycle pulse: A2D transaction finished, `rd_data` valid
- done_inert  out  1  one-cycle pulse: inertial transaction finished, `rd_data` valid
- rd_data  out  16  registered response of the last completed transaction
- err  out  1  one-cycle pulse coincident with `done_x` on watchdog timeout
- wrt  out  1  one-cycle start pulse to the SPI master
- cmd  out  16  command word to the SPI master (registered)
- sel_inert  out  1  SS_n/MISO steering: 1 = inertial, 0 = A2D
- spi_done  in  1  SPI master transaction complete (pulse)
- spi_rd  in  16  SPI master read data; valid with `spi_done`

## Operation
- States: IDLE, LAUNCH, BUSY, DONE.
- IDLE, at least one req high:
  - Pick winner. With a single requester, it wins.
  - With both requesting, the requester not served most recently wins. The `last` flag resets to "A2D served", so inertial wins the first tie.
  - Register `cmd`, `sel_inert` and the winner's `gnt`; go to LAUNCH.
- LAUNCH:
  - `wrt`=1 for exactly this cycle.
  - Clear the watchdog; go to BUSY.
  - `spi_done` is ignored here.
- BUSY:
  - Watchdog increments each cycle.
  - On `spi_done`, capture `spi_rd` into `rd_data` and go to DONE.
  - If the watchdog reaches 2^TIMEOUT_W−1 without `spi_done`, set the internal timeout flag, leave `rd_data` unchanged, and go to DONE.
  - If `spi_done` and timeout occur in the same cycle, `spi_done` wins (no `err`).
- DONE:
  - Winner's `done_x`=1 for one cycle; `err`=1 if the timeout flag is set.
  - Update `last`; go to IDLE.
  - `gnt` clears on exit.
- `sel_inert` and `cmd` hold their value in IDLE (no glitching of the SS_n mux between transactions).
- `spi_done` in IDLE or DONE is ignored.
- Requesters must drop req in the cycle after `done_x`. A req still high when IDLE re-samples is treated as a new request, and round-robin then serves the other side first if it is pending.
- Outputs `gnt_a2d` and `gnt_inert` are mutually exclusive at all times.

## Timing
- All outputs are registered or decoded from registered state only; no combinational input-to-output path.
- Reset values: `gnt_a2d`=`gnt_inert`=0, `done_*`=0, `err`=0, `wrt`=0, `cmd`=16'h0000, `rd_data`=16'h0000, `sel_inert`=0, state=IDLE, watchdog=0, `last`=A2D.
- Latency: req high in IDLE cycle N → `gnt` and `sel_inert` high at N+1 with `wrt`=1 at N+1 → BUSY from N+2.
- Completion: `spi_done` at BUSY cycle M → `rd_data` updated and `done_x`=1 at M+1 → `gnt`=0 and IDLE at M+2 → earliest next `wrt` at M+3.
- Timeout: `err` and `done_x` are asserted 2^TIMEOUT_W cycles after the LAUNCH cycle.
- Asynchronous reset mid-transaction: immediate return to reset values, no `done` pulse. The SPI master shares `rst_n`, so no half-finished transfer survives.

## Test plan
- Single A2D request, `cmd_a2d`=16'hC000 → `gnt_a2d` and `wrt` one cycle later with `cmd`=16'hC000 and `sel_inert`=0. After `spi_done` with `spi_rd`=16'h0ABC: `done_a2d`=1 one cycle and `rd_data`=16'h0ABC; `gnt_a2d`=0 the cycle after.
- Both requests high first cycle after reset → inertial served first (`sel_inert`=1), then A2D. Exactly one `done` pulse each.
- `req_inert` held continuously with `req_a2d` high → grants alternate inert, a2d, inert, a2d over 4 transactions; `gnt` signals never both high.
- TIMEOUT_W=4, no `spi_done` → `err`=1 and `done_inert`=1 exactly 16 cycles after `wrt`; `rd_data` unchanged from its previous value; next request proceeds normally.
- `rst_n` low mid-BUSY → all outputs at reset values in the same cycle, no `done` pulse; after release, a pending request is re-granted normally.
- Stray `spi_done` in IDLE and in LAUNCH → no state change, no `done`, `rd_data` unchanged.

Source files
------------

// File: rtl/spi_arb.sv
// Round-robin arbiter sharing one SPI master between the A2D and inertial interfaces, with a BUSY watchdog.
// Latency: req->wrt 1 cycle, spi_done->done_x 1 cycle; requesters hold req level until their done pulse.
module spi_arb #(
    parameter int TIMEOUT_W = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_a2d,
    input  logic [15:0] cmd_a2d,
    input  logic        req_inert,
    input  logic [15:0] cmd_inert,
    output logic        gnt_a2d,
    output logic        gnt_inert,
    output logic        done_a2d,
    output logic        done_inert,
    output logic [15:0] rd_data,
    output logic        err,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic        sel_inert,
    input  logic        spi_done,
    input  logic [15:0] spi_rd
);

    typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, DONE} state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 r_gnt_a2d;
    logic                 r_gnt_inert;
    logic                 r_sel_inert;
    logic                 r_last_inert;
    logic                 r_timeout;
    logic [15:0]          r_cmd;
    logic [15:0]          r_rd_data;
    logic [TIMEOUT_W-1:0] r_wd;
    logic [TIMEOUT_W-1:0] w_wd_inc;
    logic                 w_any_req;
    logic                 w_win_inert;
    logic                 w_timeout;

    assign w_any_req   = req_a2d | req_inert;
    // On a tie the side not served last wins; r_last_inert=0 means A2D was served last.
    assign w_win_inert = req_inert & (~req_a2d | ~r_last_inert);
    assign w_wd_inc    = r_wd + TIMEOUT_W'(1);
    assign w_timeout   = &w_wd_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_any_req) w_next = LAUNCH;
            LAUNCH:  w_next = BUSY;
            BUSY:    if (spi_done || w_timeout) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt_a2d    <= 1'b0;
            r_gnt_inert  <= 1'b0;
            r_sel_inert  <= 1'b0;
            r_last_inert <= 1'b0;
            r_timeout    <= 1'b0;
            r_cmd        <= 16'h0000;
            r_rd_data    <= 16'h0000;
            r_wd         <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_cmd       <= w_win_inert ? cmd_inert : cmd_a2d;
                        r_sel_inert <= w_win_inert;
                        r_gnt_inert <= w_win_inert;
                        r_gnt_a2d   <= ~w_win_inert;
                    end
                end
                LAUNCH: begin
                    r_wd      <= '0;
                    r_timeout <= 1'b0;
                end
                BUSY: begin
                    r_wd <= w_wd_inc;
                    // A completion arriving on the timeout cycle is a real completion, not an error.
                    if (spi_done) begin
                        r_rd_data <= spi_rd;
                    end else if (w_timeout) begin
                        r_timeout <= 1'b1;
                    end
                end
                DONE: begin
                    r_last_inert <= r_sel_inert;
                    r_gnt_a2d    <= 1'b0;
                    r_gnt_inert  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign gnt_a2d    = r_gnt_a2d;
    assign gnt_inert  = r_gnt_inert;
    assign sel_inert  = r_sel_inert;
    assign cmd        = r_cmd;
    assign rd_data    = r_rd_data;
    assign wrt        = (r_state == LAUNCH);
    assign done_a2d   = (r_state == DONE) & ~r_sel_inert;
    assign done_inert = (r_state == DONE) & r_sel_inert;
    assign err        = (r_state == DONE) & r_timeout;

endmodule

// File: tb/tb_spi_arb.sv
// Scoreboard bench for spi_arb: stimulus pushes expected launches/completions, negedge monitors pop and compare.
module tb_spi_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_a2d = 1'b0;
    logic [15:0] cmd_a2d = 16'h0000;
    logic        req_inert = 1'b0;
    logic [15:0] cmd_inert = 16'h0000;
    logic        gnt_a2d, gnt_inert, done_a2d, done_inert, err, wrt, sel_inert;
    logic [15:0] rd_data, cmd;
    logic        spi_done = 1'b0;
    logic [15:0] spi_rd = 16'h0000;

    spi_arb #(.TIMEOUT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_a2d(req_a2d), .cmd_a2d(cmd_a2d),
        .req_inert(req_inert), .cmd_inert(cmd_inert),
        .gnt_a2d(gnt_a2d), .gnt_inert(gnt_inert),
        .done_a2d(done_a2d), .done_inert(done_inert),
        .rd_data(rd_data), .err(err), .wrt(wrt), .cmd(cmd),
        .sel_inert(sel_inert), .spi_done(spi_done), .spi_rd(spi_rd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] cmd;
        logic        sel;
        int          cyc;
    } launch_t;

    typedef struct {
        logic        inert;
        logic [15:0] data;
        logic        err;
        int          cyc;
    } done_t;

    launch_t launch_q[$];
    done_t   done_q[$];
    int      checks = 0;
    int      failures = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_launch(logic [15:0] c, logic s, int at);
        launch_t l;
        l.cmd = c; l.sel = s; l.cyc = at;
        launch_q.push_back(l);
    endtask

    task automatic push_done(logic i, logic [15:0] d, logic e, int at);
        done_t x;
        x.inert = i; x.data = d; x.err = e; x.cyc = at;
        done_q.push_back(x);
    endtask

    task automatic wait_wrt();
        int n = 0;
        while (!wrt && n < 64) begin
            tick();
            n++;
        end
        if (!wrt) check("wrt_timeout", 0, 1);
    endtask

    // Acts as the SPI master: completes one cycle into BUSY with the given read data.
    task automatic serve(logic inert, logic [15:0] data);
        wait_wrt();
        tick();
        spi_rd   = data;
        spi_done = 1'b1;
        push_done(inert, data, 1'b0, cyc + 1);
        tick();
        spi_done = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("gnt_mutex", {31'b0, gnt_a2d & gnt_inert}, 0);
            check("err_without_done", {31'b0, err & ~(done_a2d | done_inert)}, 0);
            if (wrt) begin
                if (launch_q.size() == 0) begin
                    check("unexpected_wrt", 1, 0);
                end else begin
                    launch_t l;
                    l = launch_q.pop_front();
                    check("launch_cmd", {16'b0, cmd}, {16'b0, l.cmd});
                    check("launch_sel", {31'b0, sel_inert}, {31'b0, l.sel});
                    check("launch_gnt", {30'b0, gnt_inert, gnt_a2d}, {30'b0, l.sel, ~l.sel});
                    if (l.cyc >= 0) check("launch_cycle", cyc, l.cyc);
                end
            end
            if (done_a2d || done_inert) begin
                if (done_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    done_t x;
                    x = done_q.pop_front();
                    check("done_who", {30'b0, done_inert, done_a2d}, {30'b0, x.inert, ~x.inert});
                    check("done_rd_data", {16'b0, rd_data}, {16'b0, x.data});
                    check("done_err", {31'b0, err}, {31'b0, x.err});
                    if (x.cyc >= 0) check("done_cycle", cyc, x.cyc);
                end
            end
        end
    end

    task automatic check_reset_outputs(string tag);
        check({tag, "_gnt"}, {30'b0, gnt_a2d, gnt_inert}, 0);
        check({tag, "_done_err_wrt"}, {28'b0, done_a2d, done_inert, err, wrt}, 0);
        check({tag, "_cmd"}, {16'b0, cmd}, 0);
        check({tag, "_rd_data"}, {16'b0, rd_data}, 0);
        check({tag, "_sel"}, {31'b0, sel_inert}, 0);
    endtask

    initial begin
        int l_cyc;
        int n;

        // Reset state
        tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Single A2D request
        cmd_a2d = 16'hC000;
        req_a2d = 1'b1;
        push_launch(16'hC000, 1'b0, cyc + 1);
        wait_wrt();
        check("t1_gnt_in_launch", {31'b0, gnt_a2d}, 1);
        tick();
        spi_rd   = 16'h0ABC;
        spi_done = 1'b1;
        push_done(1'b0, 16'h0ABC, 1'b0, cyc + 1);
        tick();
        spi_done = 1'b0;
        req_a2d  = 1'b0;
        tick();
        check("t1_gnt_cleared", {30'b0, gnt_a2d, gnt_inert}, 0);
        check("t1_rd_data_held", {16'b0, rd_data}, 32'h0ABC);
        tick();

        // Both requests in the first cycle after reset: inertial first, then A2D
        rst_n = 1'b0;
        tick();
        cmd_a2d   = 16'h1111;
        cmd_inert = 16'h2222;
        req_a2d   = 1'b1;
        req_inert = 1'b1;
        rst_n     = 1'b1;
        push_launch(16'h2222, 1'b1, cyc + 1);
        push_launch(16'h1111, 1'b0, -1);
        serve(1'b1, 16'hAAAA);
        req_inert = 1'b0;
        serve(1'b0, 16'hBBBB);
        req_a2d = 1'b0;
        tick();

        // Both held: grants alternate inert, a2d, inert, a2d
        cmd_a2d   = 16'h0A0A;
        cmd_inert = 16'h0101;
        req_a2d   = 1'b1;
        req_inert = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_launch((i % 2 == 0) ? 16'h0101 : 16'h0A0A, (i % 2 == 0), -1);
        end
        for (int i = 0; i < 4; i++) begin
            serve((i % 2 == 0), 16'h3000 + 16'(i));
        end
        req_a2d   = 1'b0;
        req_inert = 1'b0;
        tick();

        // Watchdog: no spi_done, err with done_inert 16 cycles after wrt, rd_data kept
        cmd_inert = 16'h4444;
        req_inert = 1'b1;
        push_launch(16'h4444, 1'b1, -1);
        wait_wrt();
        l_cyc = cyc;
        push_done(1'b1, 16'h3003, 1'b1, l_cyc + 16);
        n = 0;
        while (!(done_a2d || done_inert) && n < 40) begin
            tick();
            n++;
        end
        if (!(done_a2d || done_inert)) check("timeout_never_done", 0, 1);
        req_inert = 1'b0;
        tick();
        cmd_a2d = 16'h4545;
        req_a2d = 1'b1;
        push_launch(16'h4545, 1'b0, cyc + 1);
        serve(1'b0, 16'h4A4A);
        req_a2d = 1'b0;
        tick();

        // Asynchronous reset in the middle of BUSY
        cmd_a2d = 16'h5555;
        req_a2d = 1'b1;
        push_launch(16'h5555, 1'b0, -1);
        wait_wrt();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        tick();
        rst_n = 1'b1;
        push_launch(16'h5555, 1'b0, cyc + 1);
        serve(1'b0, 16'h5A5A);
        req_a2d = 1'b0;
        tick();
        tick();

        // Stray spi_done in IDLE, then in LAUNCH
        spi_rd   = 16'hDEAD;
        spi_done = 1'b1;
        tick();
        spi_done = 1'b0;
        tick();
        check("stray_idle_rd_data", {16'b0, rd_data}, 32'h5A5A);
        check("stray_idle_no_wrt", {31'b0, wrt}, 0);
        cmd_inert = 16'h6666;
        req_inert = 1'b1;
        push_launch(16'h6666, 1'b1, -1);
        wait_wrt();
        spi_rd   = 16'hBEEF;
        spi_done = 1'b1;
        tick();
        spi_done = 1'b0;
        tick();
        check("stray_launch_rd_data", {16'b0, rd_data}, 32'h5A5A);
        check("stray_launch_still_gnt", {31'b0, gnt_inert}, 1);
        spi_rd   = 16'h6A6A;
        spi_done = 1'b1;
        push_done(1'b1, 16'h6A6A, 1'b0, cyc + 1);
        tick();
        spi_done  = 1'b0;
        req_inert = 1'b0;
        tick();
        tick();

        check("launch_queue_drained", launch_q.size(), 0);
        check("done_queue_drained", done_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "global timeout");
    end

endmodule
